// File: rtl/noc_core_injector.sv
// Core-side NoC injector: buffers payload words and emits head + body flits to the local router.
// Optional stall watchdog compiled in with NOC_INJ_TIMEOUT_EN.
module noc_core_injector #(
  parameter int unsigned ID      = 0,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  input  logic                     cmd_valid,
  input  logic [3:0]               cmd_dst,
  input  logic [$clog2(DEPTH):0]   cmd_len,
  output logic                     cmd_ready,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [33:0]              out_flit,
  output logic                     out_req,
  input  logic                     in_ack
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [3:0]  IdBits = 4'(ID);

  typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

  state_e          state_q, state_d;
  logic [33:0]     flit_q, flit_d;
  logic            req_q, req_d;
  logic [CW-1:0]   rem_q, rem_d;

  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push, pop, xfer;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_count = count_q;
  assign push       = wr_en & ~fifo_full;
  assign xfer       = req_q & in_ack;

  // Payload storage is not reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      flit_q  <= '0;
      req_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      req_q   <= req_d;
      rem_q   <= rem_d;
    end
  end

  // rem_q counts payload words still to be transferred, including the one on the wire.
  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    req_d   = req_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && (cmd_len <= count_q)) begin
          flit_d  = {1'b1, (cmd_len == '0), IdBits, cmd_dst, 8'h00, 16'(cmd_len)};
          req_d   = 1'b1;
          rem_d   = cmd_len;
          state_d = StHead;
        end
      end
      StHead: begin
        if (xfer) begin
          if (rem_q == '0) begin
            req_d   = 1'b0;
            state_d = StIdle;
          end else begin
            pop     = 1'b1;
            flit_d  = {1'b0, (rem_q == CW'(1)), mem_q[rd_ptr_q]};
            state_d = StBody;
          end
        end
      end
      StBody: begin
        if (xfer) begin
          rem_d = rem_q - 1'b1;
          if (flit_q[32]) begin
            req_d   = 1'b0;
            state_d = StIdle;
          end else begin
            pop    = 1'b1;
            flit_d = {1'b0, (rem_q == CW'(2)), mem_q[rd_ptr_q]};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_flit  = flit_q;
  assign out_req   = req_q;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

`ifdef NOC_INJ_TIMEOUT_EN
  localparam int unsigned SW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [SW-1:0] stall_q;
  logic          err_q;

  // Counter saturates at TIMEOUT; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else if (xfer) begin
      stall_q <= '0;
    end else if (req_q && !in_ack) begin
      if (stall_q != SW'(TIMEOUT)) stall_q <= stall_q + 1'b1;
      if (stall_q == SW'(TIMEOUT - 1)) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_noc_core_injector.sv
// Scoreboard bench for noc_core_injector: a word-queue model predicts every flit of each
// accepted command; a negedge monitor compares transfers and checks hold-stability.
module tb_noc_core_injector;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;
  localparam int unsigned ID    = 2;
  localparam int unsigned TMO   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd_dst = '0;
  logic [CW-1:0] cmd_len = '0;
  logic          cmd_ready, busy, err_timeout, out_req;
  logic [33:0]   out_flit;
  logic          in_ack = 1'b0;

  noc_core_injector #(.ID(ID), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .cmd_valid(cmd_valid), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .busy(busy), .err_timeout(err_timeout), .out_flit(out_flit),
    .out_req(out_req), .in_ack(in_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic [31:0] model_q[$];
  int body_left = 0;
  int ack_mode = 0;
  int cyc = 0;
  int last_xfer = -10;
  logic [33:0] held = '0;
  bit held_v = 0;
  bit tail_pending = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // 0: always ack, 1: random, 2: never, 3: repeating 1,0,0
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: in_ack = 1'b1;
        1: in_ack = 1'($urandom % 2);
        3: begin in_ack = (ph == 0); ph = (ph + 1) % 3; end
        default: in_ack = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (tail_pending) begin
      check("req_drop_after_tail", out_req, 0);
      tail_pending = 0;
    end
    if (rst && out_req) begin
      if (held_v) check("flit_hold", out_flit, held);
      if (in_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit", out_flit, 0);
          if (out_flit == 0) begin
            errors++;
            $display("FAIL unexpected_flit: got %0h expected none", out_flit);
          end
        end else begin
          e = exp_q.pop_front();
          check("flit", out_flit, e);
          if (!e[33]) begin
            body_left--;
            if (ack_mode == 0) check("back_to_back", cyc, last_xfer + 1);
          end
          last_xfer = cyc;
          if (e[32]) tail_pending = 1;
        end
        held_v = 0;
      end else begin
        held   = out_flit;
        held_v = 1;
      end
    end else begin
      held_v = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    if (model_q.size() + body_left < DEPTH) model_q.push_back(w);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue_cmd(input logic [3:0] dst, input int len, output bit acc);
    logic [33:0] h;
    acc = (len <= model_q.size());
    cmd_valid = 1'b1;
    cmd_dst   = dst;
    cmd_len   = CW'(len);
    h = (34'd1 << 33) | (34'(len == 0) << 32) | (34'(ID) << 28) | (34'(dst) << 24) | 34'(len);
    if (acc) begin
      exp_q.push_back(h);
      for (int i = 0; i < len; i++) exp_q.push_back({1'b0, (i == len - 1), model_q.pop_front()});
      body_left += len;
    end
    tick();
    cmd_valid = 1'b0;
    check("accept_busy", busy, acc);
    check("accept_req", out_req, acc);
    check("accept_ready", cmd_ready, !acc);
    if (acc) check("head_flit", out_flit, h);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && cmd_ready) && n < 2000) begin
      tick();
      n++;
    end
    check("idle_reached", (n < 2000), 1);
    check("fifo_count", fifo_count, model_q.size());
    check("fifo_full", fifo_full, model_q.size() == DEPTH);
  endtask

  task automatic send(input logic [3:0] dst, input int len, input bit mid_wr);
    bit acc;
    issue_cmd(dst, len, acc);
    if (acc && ack_mode == 0 && !mid_wr) begin
      repeat (len) tick();
      check("still_busy_on_tail", cmd_ready, 0);
      tick();
      check("idle_after_n_plus_1", cmd_ready, 1);
    end else if (mid_wr) begin
      repeat ($urandom_range(1, 6)) begin
        if (model_q.size() + body_left < DEPTH) do_write($urandom);
        else tick();
      end
    end
    wait_idle();
  endtask

  initial begin
    bit acc;
    #12;
    check("rst_out_req", out_req, 0);
    check("rst_out_flit", out_flit, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", fifo_full, 0);
    check("rst_err", err_timeout, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic 3-word packet
    ack_mode = 0;
    do_write(32'hA);
    do_write(32'hB);
    do_write(32'hC);
    check("count_3", fifo_count, 3);
    send(4'd5, 3, 0);

    // Zero-length packet
    send(4'd9, 0, 0);

    // Backpressure pattern
    ack_mode = 3;
    do_write(32'h1111);
    do_write(32'h2222);
    send(4'd1, 2, 0);

    // Full FIFO, overflow drop, wrap
    ack_mode = 0;
    for (int i = 0; i < 17; i++) do_write(32'h100 + i);
    check("full_flag", fifo_full, 1);
    check("full_count", fifo_count, 16);
    send(4'd3, 16, 0);
    for (int i = 0; i < 10; i++) do_write(32'h200 + i);
    send(4'd4, 10, 0);

    // Too-long command is ignored, then accepted once words arrive
    do_write(32'h31);
    do_write(32'h32);
    send(4'd6, 4, 0);
    do_write(32'h33);
    do_write(32'h34);
    send(4'd6, 4, 0);

    // Stall watchdog
    ack_mode = 2;
    tick();
    do_write(32'h55);
    issue_cmd(4'd7, 1, acc);
    repeat (TMO - 1) tick();
    check("err_before_limit", err_timeout, 0);
    tick();
`ifdef NOC_INJ_TIMEOUT_EN
    check("err_at_limit", err_timeout, 1);
`else
    check("err_at_limit", err_timeout, 0);
`endif
    ack_mode = 0;
    wait_idle();
`ifdef NOC_INJ_TIMEOUT_EN
    check("err_sticky", err_timeout, 1);
`else
    check("err_sticky", err_timeout, 0);
`endif

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      ack_mode = $urandom_range(0, 3);
      if (ack_mode == 2) ack_mode = 1;
      repeat ($urandom_range(0, 6)) do_write($urandom);
      send(4'($urandom), $urandom_range(0, DEPTH), 1'($urandom % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
